// File: rtl/serial_subtractor_8bit_pkg.sv
// Shared definitions for the bit-serial subtractor: default width, FSM encoding
// and the signed-overflow rule applied when the last bit retires.
// No logic of its own; imported by serial_subtractor_8bit.
package serial_subtractor_8bit_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Two's-complement overflow of a - b: operand signs differ and the
    // result sign disagrees with the minuend sign.
    function automatic logic signed_ovf(input logic sign_a, input logic sign_b,
                                        input logic sign_d);
        return (sign_a != sign_b) && (sign_d != sign_a);
    endfunction

endpackage

// File: rtl/serial_subtractor_8bit_full_subtr.sv
// One-bit full subtractor cell: diff = a - b - bin, with borrow-out.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the inputs.
// Ports: a_i (minuend bit), b_i (subtrahend bit), bin_i (borrow in),
//        diff_o (difference bit), bout_o (borrow out).
module full_subtr (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic diff_o,
    output logic bout_o
);

    assign diff_o = a_i ^ b_i ^ bin_i;
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial WIDTH-bit subtractor D = A - B - bin, LSB first, one bit per clock.
// Latency: start accepted at edge k, result and done visible after edge k+WIDTH.
// Backpressure: start is ignored while busy or in the done cycle (no queuing).
// Ports: clk/rst_n (async active-low), start/A/B/bin (launch + operands),
//        busy (operation in flight), done (1-cycle result strobe),
//        D/bout/ovf (difference, final borrow, signed overflow; held until next result).
module serial_subtractor_8bit
    import serial_subtractor_8bit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             bout,
    output logic             ovf
);

    // Counter must be able to hold WIDTH (it reaches WIDTH on the last bit).
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic             brw_q, brw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic             fs_diff;
    logic             fs_bout;

    full_subtr u_full_subtr (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .bin_i  (brw_q),
        .diff_o (fs_diff),
        .bout_o (fs_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q <= '0;
            b_sh_q <= '0;
            r_sh_q <= '0;
            brw_q  <= 1'b0;
            cnt_q  <= '0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            d_q    <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            a_sh_q <= a_sh_d;
            b_sh_q <= b_sh_d;
            r_sh_q <= r_sh_d;
            brw_q  <= brw_d;
            cnt_q  <= cnt_d;
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            d_q    <= d_d;
            bout_q <= bout_d;
            ovf_q  <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        d_d     = d_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        busy    = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    brw_d   = bin;
                    cnt_d   = '0;
                    sa_d    = A[WIDTH-1];
                    sb_d    = B[WIDTH-1];
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                busy   = 1'b1;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                r_sh_d = {fs_diff, r_sh_q[WIDTH-1:1]};
                brw_d  = fs_bout;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Last bit: fs_diff is the MSB, so the full result and the
                    // final borrow are known this cycle; publish them directly.
                    d_d     = {fs_diff, r_sh_q[WIDTH-1:1]};
                    bout_d  = fs_bout;
                    ovf_d   = signed_ovf(sa_q, sb_q, fs_diff);
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign D    = d_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
module tb_serial_subtractor_8bit;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a_in  = 8'h00;
    logic [7:0] b_in  = 8'h00;
    logic       bin_in = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] d_out;
    logic       bout;
    logic       ovf;

    typedef struct packed {
        logic [7:0] d;
        logic       bout;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    serial_subtractor_8bit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .bin   (bin_in),
        .busy  (busy),
        .done  (done),
        .D     (d_out),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed cycles=%0d required<100000", cyc);
        $fatal(1, "watchdog");
    end

    // Reference: plain 9-bit arithmetic, independent of the serial datapath.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bi);
        logic [8:0] full;
        exp_t       e;
        full   = {1'b0, a} - {1'b0, b} - {8'd0, bi};
        e.d    = full[7:0];
        e.bout = full[8];
        e.ovf  = (a[7] != b[7]) && (full[7] != a[7]);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic bo, input logic ov);
        exp_t e;
        e.d = d; e.bout = bo; e.ovf = ov;
        sb_q.push_back(e);
    endtask

    // Drive a one-cycle start; returns at the negedge after the accepting edge.
    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic bi);
        @(negedge clk);
        a_in = a; b_in = b; bin_in = bi; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a_in = 8'($urandom); b_in = 8'($urandom); bin_in = 1'($urandom);
    endtask

    // Waits (bounded) for done, then pops the scoreboard and compares.
    task automatic wait_done(input string tag, output int edges, output int busy_cnt);
        exp_t e;
        bit   seen;
        seen = 0; edges = 0; busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        if (seen) begin
            check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
            check({tag, "_sb_nonempty"}, {31'd0, (sb_q.size() > 0)}, 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({tag, "_D"},    {24'd0, d_out}, {24'd0, e.d});
                check({tag, "_bout"}, {31'd0, bout},  {31'd0, e.bout});
                check({tag, "_ovf"},  {31'd0, ovf},   {31'd0, e.ovf});
            end
        end
    endtask

    // Simple op: launch, collect, verify done drops after one cycle.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic bi, input logic [7:0] d, input logic bo, input logic ov);
        int edges, bc;
        push_exp(d, bo, ov);
        launch(a, b, bi);
        wait_done(tag, edges, bc);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    task automatic count_done(input int ncyc, output int n);
        n = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    initial begin
        int   edges, bc, c1, c2, nd;
        exp_t e;

        // Reset state
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_D",    {24'd0, d_out}, 32'd0);
        check("rst_bout", {31'd0, bout}, 32'd0);
        check("rst_ovf",  {31'd0, ovf},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // First op with latency/busy-length checks
        push_exp(8'h1E, 1'b0, 1'b0);
        launch(8'h5A, 8'h3C, 1'b0);
        wait_done("op5a3c", edges, bc);
        check("op5a3c_latency_edges", edges + 1, 32'd9);
        check("op5a3c_busy_cycles", bc, 32'd8);
        @(negedge clk);
        check("op5a3c_done_pulse", {31'd0, done}, 32'd0);

        run_op("op0001", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op("op8001", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op("op7fff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        run_op("op100f_b", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
        run_op("op0000_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);

        // Start during SHIFT must be ignored and not disturb operands
        push_exp(8'h1E, 1'b0, 1'b0);
        launch(8'h5A, 8'h3C, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_in = 8'hFF; b_in = 8'h00; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done("ign_start", edges, bc);
        count_done(15, nd);
        check("ign_start_no_extra_done", nd, 32'd0);

        // Held start: back-to-back ops every 10 cycles
        e = model(8'h22, 8'h11, 1'b0);
        sb_q.push_back(e);
        sb_q.push_back(e);
        @(negedge clk);
        a_in = 8'h22; b_in = 8'h11; bin_in = 1'b0; start = 1'b1;
        wait_done("held1", edges, bc);
        c1 = cyc;
        wait_done("held2", edges, bc);
        c2 = cyc;
        start = 1'b0;
        check("held_spacing", c2 - c1, 32'd10);
        count_done(15, nd);
        check("held_no_third", nd, 32'd0);

        // Random operands against the arithmetic model
        for (int i = 0; i < 6; i++) begin
            logic [7:0] ra, rb;
            logic       rbi;
            ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom_range(0, 1));
            e = model(ra, rb, rbi);
            run_op("rand", ra, rb, rbi, e.d, e.bout, e.ovf);
        end

        // Leave non-zero results, then abort an op with reset mid-SHIFT
        run_op("pre_rst", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        launch(8'h5A, 8'h3C, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_D",    {24'd0, d_out}, 32'd0);
        check("arst_bout", {31'd0, bout}, 32'd0);
        check("arst_ovf",  {31'd0, ovf},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(15, nd);
        check("arst_no_done_after", nd, 32'd0);
        check("arst_idle_busy", {31'd0, busy}, 32'd0);

        run_op("post_rst", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
